aes_ctr_stream: RTL and testbench

- Mode controller placed directly upstream of aes_cipher_top; wraps the bare block cipher into AES-128 CTR mode on valid/ready streams.
- Keeps key and counter state, issues one ld pulse per block, and captures text_out on done.
- XORs the keystream with the buffered plaintext block and presents the result downstream with backpressure.
- Encrypt and decrypt are the same operation.

---
 rtl/aes_ctr_stream.sv | 170 +++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream.sv
// AES-128 CTR-mode controller that drives a bare aes_cipher_top core over valid/ready streams.
// Optional cipher watchdog enabled by defining AES_CTR_TIMEOUT_EN.
module aes_ctr_stream #(
  parameter int CTR_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_ld,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic [127:0] aes_text_out,
  input  logic         aes_done,
  output logic [127:0] ctr_out,
  output logic         err
);

  if (CTR_W < 1 || CTR_W > 128 || TIMEOUT < 1) begin : g_bad_param
    $error("aes_ctr_stream: CTR_W must be 1..128 and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, READY, LOAD, WAIT, OUT} state_t;

  // Only the low CTR_W bits count; the shift by 128 yields an all-ones mask.
  localparam logic [127:0] CTR_MASK = ~({128{1'b1}} << CTR_W);

  state_t       state_q, state_d;
  logic [127:0] key_q, ctr_q, buf_q, m_data_q;
  logic [127:0] pend_key_q, pend_iv_q;
  logic         pend_q;
  logic [127:0] ctr_inc;
  logic         wd_expired;
  logic         load_cfg, apply_pend, take_in, take_out, step_ctr, park_cfg;

  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d    = state_q;
    load_cfg   = 1'b0;
    apply_pend = 1'b0;
    take_in    = 1'b0;
    take_out   = 1'b0;
    step_ctr   = 1'b0;
    park_cfg   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_ld) begin
          load_cfg = 1'b1;
          state_d  = READY;
        end
      end
      READY: begin
        if (cfg_ld) begin
          load_cfg = 1'b1;
        end else if (s_valid) begin
          take_in = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        park_cfg = cfg_ld;
        state_d  = WAIT;
      end
      WAIT: begin
        // A reconfiguration seen while the cipher was busy voids the block in flight.
        if (aes_done || wd_expired) begin
          state_d = READY;
          if (cfg_ld) begin
            load_cfg = 1'b1;
          end else if (pend_q) begin
            apply_pend = 1'b1;
          end else if (aes_done) begin
            take_out = 1'b1;
            state_d  = OUT;
          end
        end else begin
          park_cfg = cfg_ld;
        end
      end
      OUT: begin
        if (cfg_ld) begin
          load_cfg = 1'b1;
          state_d  = READY;
        end else if (m_ready) begin
          step_ctr = 1'b1;
          state_d  = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      ctr_q      <= '0;
      buf_q      <= '0;
      m_data_q   <= '0;
      pend_q     <= 1'b0;
      pend_key_q <= '0;
      pend_iv_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q <= state_d;
      if (load_cfg) begin
        key_q <= cfg_key;
        ctr_q <= cfg_iv;
      end else if (apply_pend) begin
        key_q <= pend_key_q;
        ctr_q <= pend_iv_q;
      end else if (step_ctr) begin
        ctr_q <= ctr_inc;
      end
      if (park_cfg) begin
        pend_q     <= 1'b1;
        pend_key_q <= cfg_key;
        pend_iv_q  <= cfg_iv;
      end else if (load_cfg || apply_pend) begin
        pend_q <= 1'b0;
      end
      if (take_in)  buf_q    <= s_data;
      if (take_out) m_data_q <= aes_text_out ^ buf_q;
    end
  end

`ifdef AES_CTR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;

  // Counts WAIT cycles; expiry lands on the TIMEOUT-th WAIT cycle without aes_done.
  assign wd_expired = (state_q == WAIT) && !aes_done && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
      if (wd_expired) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  assign s_ready     = (state_q == READY);
  assign m_valid     = (state_q == OUT);
  assign aes_ld      = (state_q == LOAD);
  assign aes_key     = key_q;
  assign aes_text_in = ctr_q;
  assign ctr_out     = ctr_q;
  assign m_data      = m_data_q;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Self-checking bench for aes_ctr_stream: stub cipher plus transaction-level CTR reference model.
// Define AES_CTR_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
`timescale 1ns/1ps
module tb_aes_ctr_stream;
  localparam int CTR_W   = 32;
  localparam int TIMEOUT = 64;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1 = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2 = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] WRAP_IV  = 128'h0123456789abcdef00000000ffffffff;
  localparam logic [127:0] WRAP_END = 128'h0123456789abcdef0000000000000000;

  logic         clk = 1'b0;
  logic         rst, cfg_ld, s_valid, m_ready;
  logic [127:0] cfg_key, cfg_iv, s_data;
  logic         s_ready, m_valid, aes_ld, err;
  logic [127:0] m_data, aes_key, aes_text_in, ctr_out;
  logic         aes_done = 1'b0;
  logic [127:0] aes_text_out = '0;

  always #5 clk = ~clk;

  aes_ctr_stream #(.CTR_W(CTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_ld(cfg_ld), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
    .aes_text_out(aes_text_out), .aes_done(aes_done),
    .ctr_out(ctr_out), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Real AES-128 results for the two SP800-38A blocks; a keyed toy mix elsewhere.
  function automatic logic [127:0] cipher_ref(input logic [127:0] key, input logic [127:0] txt);
    logic [127:0] x;
    if (key == K1 && txt == IV1) return KS1;
    if (key == K1 && txt == IV2) return KS2;
    x = txt ^ key;
    x = {x[86:0], x[127:87]} + {key[63:0], key[127:64]};
    x = x ^ (x >> 29) ^ {txt[31:0], txt[127:32]};
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stub cipher: latches key/text on aes_ld, answers with one done pulse after a delay.
  int           stub_fix_lat  = -1;
  int           stub_last_lat = 0;
  int           stub_cnt      = 0;
  bit           stub_busy     = 1'b0;
  bit           stub_hang     = 1'b0;
  bit           stab_en       = 1'b1;
  bit           unstable      = 1'b0;
  int           ld_count      = 0;
  logic [127:0] stub_key, stub_txt, ld_key_last, ld_txt_last;

  always @(negedge clk) begin
    aes_done     = 1'b0;
    aes_text_out = rand128();
    if (stub_busy) begin
      if (stab_en && (aes_key !== stub_key || aes_text_in !== stub_txt)) unstable = 1'b1;
      if (stub_cnt == 0) begin
        if (!stub_hang) begin
          aes_done     = 1'b1;
          aes_text_out = cipher_ref(stub_key, stub_txt);
        end
        stub_busy = 1'b0;
      end else begin
        stub_cnt--;
      end
    end
    if (aes_ld) begin
      ld_count++;
      ld_key_last   = aes_key;
      ld_txt_last   = aes_text_in;
      stub_key      = aes_key;
      stub_txt      = aes_text_in;
      stub_last_lat = (stub_fix_lat >= 0) ? stub_fix_lat : int'($urandom_range(0, 6));
      stub_cnt      = stub_last_lat;
      stub_busy     = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reference model: current key and counter block as the stream should see them.
  logic [127:0] m_key, m_ctr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv);
    cfg_key = k;
    cfg_iv  = iv;
    cfg_ld  = 1'b1;
    tick();
    cfg_ld = 1'b0;
    m_key  = k;
    m_ctr  = iv;
  endtask

  task automatic start_block(input string tag, input logic [127:0] pt);
    int ld0, n;
    ld0     = ld_count;
    s_data  = pt;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_s_ready"}, s_ready, 1);
    tick();
    s_valid = 1'b0;
    s_data  = rand128();
    check({tag, "_ld_next_cycle"}, aes_ld, 1);
    n = 0;
    while (!m_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, stub_last_lat + 2);
    check({tag, "_ld_count"}, ld_count - ld0, 1);
    check({tag, "_ld_text"}, ld_txt_last, m_ctr);
    check({tag, "_ld_key"}, ld_key_last, m_key);
  endtask

  task automatic finish_block(input string tag, input int hold, input logic [127:0] exp_ct);
    logic [127:0] d0;
    bit           ok;
    ok = 1'b1;
    d0 = m_data;
    for (int i = 0; i < hold; i++) begin
      if (!m_valid || m_data !== d0 || s_ready || aes_ld || ctr_out !== m_ctr) ok = 1'b0;
      tick();
    end
    if (hold > 0) check({tag, "_hold_stable"}, ok, 1);
    check({tag, "_m_valid"}, m_valid, 1);
    check({tag, "_m_data"}, m_data, exp_ct);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    m_ctr   = {m_ctr[127:CTR_W], m_ctr[CTR_W-1:0] + 1'b1};
    check({tag, "_ctr_after"}, ctr_out, m_ctr);
    check({tag, "_single_xfer"}, m_valid, 0);
    check({tag, "_ready_again"}, s_ready, 1);
  endtask

  initial begin
    logic [127:0] pt, iv, k2, k3, k4, iv3, iv4;
    bit           seen;

    rst = 1'b0; cfg_ld = 1'b0; cfg_key = '0; cfg_iv = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    k2 = rand128(); k3 = rand128(); k4 = rand128();
    iv3 = rand128(); iv4 = rand128();
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_aes_ld", aes_ld, 0);
    check("rst_aes_key", aes_key, 0);
    check("rst_text_in", aes_text_in, 0);
    check("rst_ctr_out", ctr_out, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    check("idle_no_accept", aes_ld, 0);
    check("idle_s_ready", s_ready, 0);

    // SP800-38A CTR blocks 1 and 2, back to back, then a 20-cycle stall.
    do_cfg(K1, IV1);
    check("cfg_key", aes_key, K1);
    check("cfg_ctr", ctr_out, IV1);
    start_block("v1", PT1);
    finish_block("v1", 0, CT1);
    check("v2_ctr", ctr_out, IV2);
    start_block("v2", PT2);
    finish_block("v2", 0, CT2);
    pt = rand128();
    start_block("bp", pt);
    finish_block("bp", 20, pt ^ cipher_ref(m_key, m_ctr));

    // Counter field wraps without carry into the upper IV bits.
    do_cfg(k2, WRAP_IV);
    pt = rand128();
    start_block("wrap", pt);
    finish_block("wrap", 1, pt ^ cipher_ref(m_key, m_ctr));
    check("wrap_ctr_const", ctr_out, WRAP_END);

    // cfg_ld in LOAD then again in WAIT: block dropped, latest config applied.
    stub_fix_lat = 6;
    s_data = rand128(); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("rc_ld", aes_ld, 1);
    cfg_key = k4; cfg_iv = iv4; cfg_ld = 1'b1;
    tick();
    cfg_key = k3; cfg_iv = iv3;
    tick();
    cfg_ld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) seen = 1'b1;
      tick();
    end
    check("rc_no_m_valid", seen, 0);
    check("rc_ready", s_ready, 1);
    check("rc_ctr", ctr_out, iv3);
    check("rc_key", aes_key, k3);
    m_key = k3; m_ctr = iv3;
    stub_fix_lat = -1;
    pt = rand128();
    start_block("rc_next", pt);
    finish_block("rc_next", 1, pt ^ cipher_ref(k3, iv3));

    // cfg_ld while output pending drops it without advancing the counter.
    pt = rand128();
    start_block("co", pt);
    iv = rand128();
    do_cfg(K1, iv);
    check("co_drop", m_valid, 0);
    check("co_ready", s_ready, 1);
    check("co_ctr", ctr_out, iv);

    // cfg_ld wins over a simultaneous s_valid in READY.
    s_data = rand128(); s_valid = 1'b1;
    iv = rand128();
    do_cfg(k2, iv);
    s_valid = 1'b0;
    check("cs_no_accept", aes_ld, 0);
    check("cs_ready", s_ready, 1);
    check("cs_ctr", ctr_out, iv);

    // Randomized traffic with occasional reconfiguration and near-wrap counters.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        iv = rand128();
        if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffffffff - $urandom_range(0, 2);
        do_cfg(rand128(), iv);
      end
      pt = rand128();
      start_block("rnd", pt);
      finish_block("rnd", int'($urandom_range(0, 3)), pt ^ cipher_ref(m_key, m_ctr));
    end

    // Reset during WAIT; the stale done that follows must be ignored.
    stub_fix_lat = 5;
    stab_en = 1'b0;
    s_data = rand128(); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_aes_ld", aes_ld, 0);
    check("mid_rst_aes_key", aes_key, 0);
    check("mid_rst_text_in", aes_text_in, 0);
    check("mid_rst_ctr_out", ctr_out, 0);
    check("mid_rst_err", err, 0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid || s_ready || aes_ld) seen = 1'b1;
      tick();
    end
    check("stale_done_ignored", seen, 0);
    stab_en = 1'b1;
    stub_fix_lat = -1;
    do_cfg(K1, IV1);
    start_block("post_rst", PT1);
    finish_block("post_rst", 2, CT1);

`ifdef AES_CTR_TIMEOUT_EN
    iv = rand128();
    do_cfg(k2, iv);
    stub_hang = 1'b1;
    s_data = rand128(); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("to_err_early", err, 0);
    check("to_wait_early", s_ready, 0);
    tick();
    check("to_err", err, 1);
    check("to_ready", s_ready, 1);
    check("to_no_out", m_valid, 0);
    check("to_ctr", ctr_out, iv);
    stub_hang = 1'b0;
    repeat (8) tick();
    pt = rand128();
    start_block("to_next", pt);
    finish_block("to_next", 0, pt ^ cipher_ref(m_key, m_ctr));
    check("to_sticky", err, 1);
`else
    check("err_tied_low", err, 0);
`endif

    check("text_key_stable", unstable, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
